cpu_wrapper_v3: RTL and testbench
=================================

# cpu_wrapper_v3

Top-level wrapper of the 8-bit, 5-stage pipelined teaching CPU. It contains the program counter, a unified 256x8 memory, a 4x8 register file, the ALU, forwarding logic, an input port, a registered output port and a single-level interrupt. Benches preload memory through hierarchy and observe `O_Port`, the registers and the PC.

## Interface
- No parameters.
- `clk` in 1 — single clock; all state changes on the rising edge.
- `rstn` in 1 — asynchronous, active-high reset. `rstn=1` resets; `rstn=0` runs.
- `I_Port` in 8 — input port, sampled by IN.
- `int_sig` in 1 — interrupt request; a rising edge is detected.
- `O_Port` out 8 — output port register, written by OUT.
- Required hierarchy, because benches poke and peek these:
  - `mem_inst.mem[0:255]` (8-bit).
  - `regfile_inst.regs[0:3]` (8-bit).
  - `PC.pc_current` (8-bit).

## Operation
- Encoding: `op=instr[7:4]`, `ra=instr[3:2]`, `rb=instr[1:0]`. Registers R0..R3.
- Opcodes:
  - `0x0` NOP.
  - `0x1` MOV: R[ra]←R[rb].
  - `0x2` ADD: R[ra]←R[ra]+R[rb].
  - `0x3` SUB: R[ra]←R[ra]−R[rb].
  - `0x4` AND.
  - `0x5` OR.
  - `0x7` I/O group, selected by `ra`:
    - `ra=0` RTI.
    - `ra=1` OUT: O_Port←R[rb].
    - `ra=2` NOP.
    - `ra=3` IN: R[rb]←I_Port.
  - `0xC` LDM (2 bytes): R[rb]←mem[PC+1]. `ra` is ignored.
  - All other opcodes execute as NOP.
- Flags Z, N, C are internal. They are updated only by ADD, SUB, AND and OR.
  - ADD: C = carry-out, 8-bit wrap.
  - SUB: C = borrow.
  - AND/OR: C is unchanged.
- Memory:
  - Asynchronous dual read: `mem[PC]` and `mem[PC+1]`, with the address wrapping mod 256.
  - No runtime write port. Reset never clears memory.
- Fetch reads two bytes per cycle. PC advances by 2 when `op=0xC`, otherwise by 1, wrapping at 0xFF→0x00. LDM therefore inserts no bubble.
- Pipeline stages are IF, ID, EX, MEM, WB.
  - The register file and `O_Port` are written at the end of WB.
  - The register file is write-first, so a read in the same cycle as a write returns the new value.
- Forwarding into EX:
  - Sources: EX/MEM and MEM/WB. The younger source has priority.
  - Covers every RAW hazard.
  - No stalls are ever required.
- Interrupt:
  - A rising edge of `int_sig` sets `pending`, unless `in_isr` is already set.
  - While `pending`, the next fetch is replaced by a redirect: `ret_pc`←PC, PC←0xF0, `in_isr`←1, `pending`←0.
  - Instructions already in flight complete normally.
- RTI:
  - Resolved in ID: PC←`ret_pc`, `in_isr`←0.
  - The single instruction currently in IF is squashed to a NOP.

## Timing
- Reset state while `rstn=1`:
  - PC=0x00, all regs=0x00, `O_Port`=0x00.
  - Flags=0; `pending`, `in_isr` and `ret_pc` are 0.
  - All pipeline registers hold NOP.
- Reset has immediate (asynchronous) effect, including mid-program. Any in-flight instructions are discarded.
- Edge numbering: the first rising edge after `rstn` falls is edge 1.
  - An instruction latched into IF/ID at edge k commits (register or `O_Port` write) at edge k+4.
  - The instruction at address 0 commits at edge 5.
- Throughput: one instruction per cycle, with one squash after RTI.
- `int_sig` edge detection uses the previous-cycle sample. The redirect occurs at the edge after detection.
- Simultaneous write to the same register from two stages cannot occur, because in-order WB writes one register per cycle.

## Test plan
- **Output port.**
  - Stimulus: mem[0..3]={C1,55,75,00}, then release reset.
  - Required: R1=0x55 at edge 5; `O_Port`=0x55 at edge 6 (LDM→OUT forwarding).
- **Input port.**
  - Stimulus: `I_Port`=0xA3; program 7D (IN R1), 75 (OUT R1).
  - Required: R1=0xA3 and `O_Port`=0xA3.
- **ALU chain with forwarding.**
  - Program: C0 FF, C1 01, 21 (ADD R0,R1), 74 (OUT R0).
  - Required: R0=0x00, `O_Port`=0x00, Z=1, C=1.
- **Reset mid-program.**
  - Stimulus: assert `rstn` at edge 3 of the previous program.
  - Required: `O_Port`, regs and PC are 0 immediately; the program re-runs identically after release.
- **Interrupt.**
  - Setup: ISR at 0xF0 is C2 77, 76 (OUT R2), 70 (RTI). Main program is a NOP loop.
  - Stimulus: pulse `int_sig`.
  - Required: `O_Port`=0x77, then PC returns to the saved address. A second pulse while `in_isr`=1 is ignored.
- **Wrap.**
  - Stimulus: LDM placed at 0xFF, with its immediate read from mem[0x00].
  - Required: PC wraps to 0x01.

Source files
------------

// File: rtl/cpu_wrapper_v3.sv
// Five-stage 8-bit teaching CPU: PC, unified 256x8 memory, 4x8 register file,
// ALU with EX forwarding from EX/MEM and MEM/WB, I/O ports, one-level interrupt.

module cpu_wrapper_v3 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] I_Port,
  input  logic       int_sig,
  output logic [7:0] O_Port
);
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_IO  = 4'h7;
  localparam logic [3:0] OP_LDM = 4'hC;

  logic [7:0] pc_cur, pc_d, fetch_instr, fetch_imm;
  logic [7:0] ifid_instr_q, ifid_instr_d, ifid_imm_q, ifid_imm_d;
  logic [7:0] idex_instr_q, idex_imm_q, idex_a_q, idex_b_q;
  logic [7:0] id_a, id_b;
  logic       id_rti, int_rise;
  logic       int_prev_q, pending_q, pending_d, in_isr_q, in_isr_d;
  logic [7:0] ret_pc_q, ret_pc_d;
  logic [7:0] exm_res_q, wb_res_q;
  logic       exm_we_q, wb_we_q, exm_out_q, wb_out_q;
  logic [1:0] exm_dst_q, wb_dst_q;
  logic [3:0] ex_op;
  logic [1:0] ex_ra, ex_rb, ex_dst;
  logic [7:0] ex_a, ex_b, ex_res;
  logic [8:0] ex_wide;
  logic       ex_we, ex_out, ex_flag_en, ex_c_en;
  logic       z_q, n_q, c_q;

  cpu_pc PC (.clk_i(clk), .rst_i(rstn), .pc_d_i(pc_d), .pc_o(pc_cur));

  cpu_mem mem_inst (
    .raddr0_i(pc_cur), .raddr1_i(pc_cur + 8'd1),
    .rdata0_o(fetch_instr), .rdata1_o(fetch_imm)
  );

  cpu_regfile regfile_inst (
    .clk_i(clk), .rst_i(rstn),
    .we_i(wb_we_q), .waddr_i(wb_dst_q), .wdata_i(wb_res_q),
    .raddr_a_i(ifid_instr_q[3:2]), .raddr_b_i(ifid_instr_q[1:0]),
    .rdata_a_o(id_a), .rdata_b_o(id_b)
  );

  assign id_rti   = (ifid_instr_q[7:2] == 6'b0111_00);
  assign int_rise = int_sig & ~int_prev_q;

  // Fetch steering: RTI in ID beats a pending interrupt; both replace the fetch with a NOP.
  always_comb begin
    pc_d         = pc_cur + ((fetch_instr[7:4] == OP_LDM) ? 8'd2 : 8'd1);
    ifid_instr_d = fetch_instr;
    ifid_imm_d   = fetch_imm;
    ret_pc_d     = ret_pc_q;
    in_isr_d     = in_isr_q;
    pending_d    = pending_q;
    if (id_rti) begin
      pc_d         = ret_pc_q;
      ifid_instr_d = 8'h00;
      ifid_imm_d   = 8'h00;
      in_isr_d     = 1'b0;
    end else if (pending_q) begin
      ret_pc_d     = pc_cur;
      pc_d         = 8'hF0;
      ifid_instr_d = 8'h00;
      ifid_imm_d   = 8'h00;
      in_isr_d     = 1'b1;
      pending_d    = 1'b0;
    end else if (int_rise && !in_isr_q) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Front end: IF/ID, ID/EX and interrupt bookkeeping.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ifid_instr_q <= 8'h00;
      ifid_imm_q   <= 8'h00;
      idex_instr_q <= 8'h00;
      idex_imm_q   <= 8'h00;
      idex_a_q     <= 8'h00;
      idex_b_q     <= 8'h00;
      int_prev_q   <= 1'b0;
      pending_q    <= 1'b0;
      in_isr_q     <= 1'b0;
      ret_pc_q     <= 8'h00;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_imm_q   <= ifid_imm_d;
      idex_instr_q <= ifid_instr_q;
      idex_imm_q   <= ifid_imm_q;
      idex_a_q     <= id_a;
      idex_b_q     <= id_b;
      int_prev_q   <= int_sig;
      pending_q    <= pending_d;
      in_isr_q     <= in_isr_d;
      ret_pc_q     <= ret_pc_d;
    end
  end

  assign ex_op = idex_instr_q[7:4];
  assign ex_ra = idex_instr_q[3:2];
  assign ex_rb = idex_instr_q[1:0];
  // Younger producer (EX/MEM) wins over MEM/WB; older values arrive via the write-first regfile.
  assign ex_a = (exm_we_q && exm_dst_q == ex_ra) ? exm_res_q :
                (wb_we_q  && wb_dst_q  == ex_ra) ? wb_res_q  : idex_a_q;
  assign ex_b = (exm_we_q && exm_dst_q == ex_rb) ? exm_res_q :
                (wb_we_q  && wb_dst_q  == ex_rb) ? wb_res_q  : idex_b_q;

  // Execute: result, destination and flag enables per opcode.
  always_comb begin
    ex_res     = 8'h00;
    ex_wide    = 9'h000;
    ex_we      = 1'b0;
    ex_out     = 1'b0;
    ex_dst     = ex_ra;
    ex_flag_en = 1'b0;
    ex_c_en    = 1'b0;
    case (ex_op)
      OP_MOV: begin ex_res = ex_b; ex_we = 1'b1; end
      OP_ADD: begin
        ex_wide = {1'b0, ex_a} + {1'b0, ex_b};
        ex_res  = ex_wide[7:0];
        ex_we   = 1'b1; ex_flag_en = 1'b1; ex_c_en = 1'b1;
      end
      OP_SUB: begin
        ex_wide = {1'b0, ex_a} - {1'b0, ex_b};
        ex_res  = ex_wide[7:0];
        ex_we   = 1'b1; ex_flag_en = 1'b1; ex_c_en = 1'b1;
      end
      OP_AND: begin ex_res = ex_a & ex_b; ex_we = 1'b1; ex_flag_en = 1'b1; end
      OP_OR:  begin ex_res = ex_a | ex_b; ex_we = 1'b1; ex_flag_en = 1'b1; end
      OP_IO: begin
        case (ex_ra)
          2'd1:    begin ex_res = ex_b; ex_out = 1'b1; end
          2'd3:    begin ex_res = I_Port; ex_we = 1'b1; ex_dst = ex_rb; end
          default: ex_res = 8'h00;
        endcase
      end
      OP_LDM:  begin ex_res = idex_imm_q; ex_we = 1'b1; ex_dst = ex_rb; end
      default: ex_res = 8'h00;
    endcase
  end

  // Back end: EX/MEM, MEM/WB, flags and the output port.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      exm_res_q <= 8'h00; exm_we_q <= 1'b0; exm_out_q <= 1'b0; exm_dst_q <= 2'd0;
      wb_res_q  <= 8'h00; wb_we_q  <= 1'b0; wb_out_q  <= 1'b0; wb_dst_q  <= 2'd0;
      z_q <= 1'b0; n_q <= 1'b0; c_q <= 1'b0;
      O_Port <= 8'h00;
    end else begin
      exm_res_q <= ex_res; exm_we_q <= ex_we; exm_out_q <= ex_out; exm_dst_q <= ex_dst;
      wb_res_q  <= exm_res_q; wb_we_q <= exm_we_q; wb_out_q <= exm_out_q; wb_dst_q <= exm_dst_q;
      if (ex_flag_en) begin
        z_q <= (ex_res == 8'h00);
        n_q <= ex_res[7];
      end
      if (ex_c_en) begin
        c_q <= ex_wide[8];
      end
      if (wb_out_q) begin
        O_Port <= wb_res_q;
      end
    end
  end
endmodule

module cpu_pc (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] pc_d_i,
  output logic [7:0] pc_o
);
  logic [7:0] pc_current;

  // Program counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_current <= 8'h00;
    end else begin
      pc_current <= pc_d_i;
    end
  end

  assign pc_o = pc_current;
endmodule

module cpu_mem (
  input  logic [7:0] raddr0_i,
  input  logic [7:0] raddr1_i,
  output logic [7:0] rdata0_o,
  output logic [7:0] rdata1_o
);
  // Contents are preloaded from outside; reset leaves them untouched.
  logic [7:0] mem [0:255];

  assign rdata0_o = mem[raddr0_i];
  assign rdata1_o = mem[raddr1_i];
endmodule

module cpu_regfile (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] raddr_a_i,
  input  logic [1:0] raddr_b_i,
  output logic [7:0] rdata_a_o,
  output logic [7:0] rdata_b_o
);
  logic [7:0] regs [0:3];

  // Register array, written at the end of WB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (we_i) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (we_i && waddr_i == raddr_a_i) ? wdata_i : regs[raddr_a_i];
  assign rdata_b_o = (we_i && waddr_i == raddr_b_i) ? wdata_i : regs[raddr_b_i];
endmodule

// File: tb/tb_cpu_wrapper_v3.sv
// Directed bench for cpu_wrapper_v3: program table plus latency, reset, interrupt and wrap sequences.

module tb_cpu_wrapper_v3;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] I_Port = 8'h00;
  logic       int_sig = 1'b0;
  logic [7:0] O_Port;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] prog;   // bytes for mem[0..7], mem[0] in the top byte
    logic [7:0]  iport;
    logic [7:0]  edges;
    logic [31:0] regs;   // {R0,R1,R2,R3}
    logic [7:0]  oport;
    logic [7:0]  pc;
    logic [2:0]  znc;
  } vec_t;

  vec_t vecs [6];

  cpu_wrapper_v3 dut (.clk(clk), .rstn(rstn), .I_Port(I_Port), .int_sig(int_sig), .O_Port(O_Port));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut.mem_inst.mem[i] = 8'h00;
  endtask

  task automatic load(input logic [63:0] prog);
    clear_mem();
    for (int i = 0; i < 8; i++) dut.mem_inst.mem[i] = prog[63-8*i -: 8];
  endtask

  // Release on the cycle after an edge so the next rising edge is edge 1.
  task automatic release_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] regs, input logic [7:0] op,
                             input logic [7:0] pc);
    for (int r = 0; r < 4; r++)
      check($sformatf("%s R%0d", tag, r), dut.regfile_inst.regs[r], regs[31-8*r -: 8]);
    check({tag, " O_Port"}, O_Port, op);
    check({tag, " PC"}, dut.PC.pc_current, pc);
  endtask

  initial begin
    vecs[0] = '{prog:64'hC155_7500_0000_0000, iport:8'h00, edges:8'd8,  regs:32'h0055_0000, oport:8'h55, pc:8'h09, znc:3'b000};
    vecs[1] = '{prog:64'h7D75_0000_0000_0000, iport:8'hA3, edges:8'd8,  regs:32'h00A3_0000, oport:8'hA3, pc:8'h08, znc:3'b000};
    vecs[2] = '{prog:64'hC0FF_C101_2174_0000, iport:8'h00, edges:8'd10, regs:32'h0001_0000, oport:8'h00, pc:8'h0C, znc:3'b101};
    vecs[3] = '{prog:64'hC005_C107_3174_0000, iport:8'h00, edges:8'd10, regs:32'hFE07_0000, oport:8'hFE, pc:8'h0C, znc:3'b011};
    vecs[4] = '{prog:64'hC0C3_C13C_1841_5976, iport:8'h00, edges:8'd12, regs:32'h003C_FF00, oport:8'hFF, pc:8'h0E, znc:3'b010};
    vecs[5] = '{prog:64'hC001_2020_7400_0000, iport:8'h00, edges:8'd10, regs:32'h0400_0000, oport:8'h04, pc:8'h0B, znc:3'b000};

    // Reset state.
    tick(1);
    check_state("reset", 32'h0, 8'h00, 8'h00);
    check("reset flags", {5'b0, dut.z_q, dut.n_q, dut.c_q}, 8'h00);

    for (int v = 0; v < 6; v++) begin
      rstn = 1'b1;
      I_Port = vecs[v].iport;
      load(vecs[v].prog);
      release_reset();
      tick(int'(vecs[v].edges));
      check_state($sformatf("vec%0d", v), vecs[v].regs, vecs[v].oport, vecs[v].pc);
      check($sformatf("vec%0d flags", v), {5'b0, dut.z_q, dut.n_q, dut.c_q}, {5'b0, vecs[v].znc});
    end

    // Commit latency of LDM and LDM->OUT forwarding, then asynchronous reset of O_Port.
    rstn = 1'b1;
    I_Port = 8'h00;
    load(64'hC155_7500_0000_0000);
    release_reset();
    tick(4);
    check("lat R1 e4", dut.regfile_inst.regs[1], 8'h00);
    tick(1);
    check("lat R1 e5", dut.regfile_inst.regs[1], 8'h55);
    check("lat O e5", O_Port, 8'h00);
    tick(1);
    check("lat O e6", O_Port, 8'h55);
    rstn = 1'b1;
    #1;
    check_state("async rst", 32'h0, 8'h00, 8'h00);

    // Reset at edge 3 of the ALU chain, then the program must re-run identically.
    load(64'hC0FF_C101_2174_0000);
    release_reset();
    tick(3);
    check("mid PC e3", dut.PC.pc_current, 8'h05);
    rstn = 1'b1;
    #1;
    check_state("mid rst", 32'h0, 8'h00, 8'h00);
    release_reset();
    tick(10);
    check_state("rerun", 32'h0001_0000, 8'h00, 8'h0C);
    check("rerun flags", {5'b0, dut.z_q, dut.n_q, dut.c_q}, 8'h05);

    // Interrupt into ISR at 0xF0, RTI back to the saved PC, second pulse ignored.
    rstn = 1'b1;
    clear_mem();
    dut.mem_inst.mem[8'hF0] = 8'hC2;
    dut.mem_inst.mem[8'hF1] = 8'h77;
    dut.mem_inst.mem[8'hF2] = 8'h76;
    dut.mem_inst.mem[8'hF3] = 8'h70;
    release_reset();
    tick(3);
    int_sig = 1'b1;
    tick(1);
    check("irq pending e4", {7'b0, dut.pending_q}, 8'h01);
    tick(1);
    check("irq PC e5", dut.PC.pc_current, 8'hF0);
    check("irq in_isr e5", {7'b0, dut.in_isr_q}, 8'h01);
    int_sig = 1'b0;
    tick(1);
    int_sig = 1'b1;
    tick(1);
    check("irq 2nd ignored", {7'b0, dut.pending_q}, 8'h00);
    tick(1);
    int_sig = 1'b0;
    tick(1);
    check("rti PC e9", dut.PC.pc_current, 8'h04);
    check("rti in_isr e9", {7'b0, dut.in_isr_q}, 8'h00);
    tick(2);
    check("isr O e11", O_Port, 8'h77);
    check("isr R2 e11", dut.regfile_inst.regs[2], 8'h77);
    tick(1);
    check("post PC e12", dut.PC.pc_current, 8'h07);

    // LDM at 0xFF takes its immediate from mem[0x00] and the PC wraps to 0x01.
    rstn = 1'b1;
    clear_mem();
    dut.mem_inst.mem[8'hFF] = 8'hC3;
    dut.mem_inst.mem[8'h00] = 8'h5A;
    release_reset();
    tick(255);
    check("wrap PC e255", dut.PC.pc_current, 8'hFF);
    tick(1);
    check("wrap PC e256", dut.PC.pc_current, 8'h01);
    tick(4);
    check("wrap R3", dut.regfile_inst.regs[3], 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
